full_adder_bist: RTL
====================

// Module: full_adder_bist
// PURPOSE
//  Built-in self-test engine for a 1-bit full adder. It is the response side of the exhaustive
//  a/b/c_in sweep: it drives all 8 input vectors into a DUT adder, samples sum/carry_out and
//  checks them against the expected values. It reports an error count, the first failing
//  vector and pass/done. It sits beside the adder under test in chapter-3 designs.
// PARAMETERS
//  SETTLE_CYCLES  1  cycles each vector is held before the response is sampled (must be >= 1)
//  ERR_W          4  width of err_count (must be >= 2)
// PORTS
//  clk               in   1      single clock, rising edge
//  rst_n             in   1      asynchronous, active-low reset
//  start             in   1      begin a sweep; sampled only in IDLE or DONE
//  a                 out  1      stimulus to DUT a        (= vec[2])
//  b                 out  1      stimulus to DUT b        (= vec[1])
//  carry_in          out  1      stimulus to DUT carry_in (= vec[0])
//  sum               in   1      DUT sum response
//  carry_out         in   1      DUT carry_out response
//  busy              out  1      sweep in progress (DRIVE or CHECK)
//  done              out  1      sweep finished; held until start or reset
//  pass              out  1      done && err_count==0
//  err_count         out  ERR_W  number of failing vectors, saturating
//  first_fail_vec    out  3      {a,b,carry_in} of the first failing vector
//  first_fail_valid  out  1      first_fail_vec holds a captured value
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; vec=0; settle counter=0. All outputs are 0:
//    a, b, carry_in, busy, done, pass, err_count, first_fail_vec and first_fail_valid.
//  - All outputs are registered. a/b/carry_in always equal the current vec register.
//  - FSM states: IDLE, DRIVE, CHECK, DONE.
//    IDLE : start=1 -> DRIVE. vec=0, err_count=0, first_fail_valid=0, settle counter=0.
//    DRIVE: busy=1. Vec is held for SETTLE_CYCLES cycles, then the FSM goes to CHECK.
//    CHECK: busy=1, one cycle. Expected sum = a^b^c_in; expected carry = majority(a,b,c_in).
//           On a mismatch in sum OR carry_out:
//             err_count+=1 (it saturates at 2^ERR_W-1);
//             if first_fail_valid==0, capture vec into first_fail_vec and set first_fail_valid.
//           Then: if vec==7 -> DONE; else vec+=1, settle counter=0, -> DRIVE.
//    DONE : done=1, busy=0. pass=(err_count==0). All results are held.
//           start=1 -> behaves as start in IDLE: results cleared, new sweep from vec 0.
//  - Each vector counts as one failure at most, even if both responses are wrong.
//  - start while busy is ignored. start must be a level or a pulse; there is no edge detection.
//  - Latency: take the clock edge that samples start as edge 0. done=1 after edge 8*(SETTLE_CYCLES+1).
//    With the default this is edge 16.
//  - DUT response is sampled at the end of the CHECK cycle. The vector has then been stable for
//    SETTLE_CYCLES+1 cycles.
//  - Reset mid-sweep: immediate return to the reset values. The next start begins again at vec 0.
//  - vec wrap: vec never goes past 7. There is no wrap to 0 inside a sweep.
// TESTING
//  1 Golden adder model as DUT, start pulse -> vectors sweep 0..7.
//    done=1 at edge 16, pass=1, err_count=0, first_fail_valid=0.
//  2 DUT sum stuck at 0 -> failures at vec 1,2,4,7.
//    err_count=4, first_fail_vec=3'b001, pass=0.
//  3 DUT carry_out inverted -> err_count=8, first_fail_vec=3'b000.
//    With ERR_W=2 the same case gives err_count=3 (saturated).
//  4 start re-asserted at vec 3 -> ignored, done still at edge 16.
//    start in DONE -> results cleared, new sweep, done again after 16 more edges.
//  5 rst_n low while vec=5 -> all outputs 0 immediately, FSM in IDLE.
//    Next start restarts from vec 0 with err_count=0.
//  6 SETTLE_CYCLES=3 -> each vector is held for 3 DRIVE cycles plus 1 CHECK cycle; done at edge 32.

Source files
------------

// File: rtl/full_adder_bist.sv
// Response-side BIST for a 1-bit full adder: sweeps a/b/carry_in through all 8 vectors,
// checks sum/carry_out and reports error count, first failing vector and pass/done.
module full_adder_bist #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             carry_in,
    input  logic             sum,
    input  logic             carry_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       first_fail_vec,
    output logic             first_fail_valid
);

    localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StDrive, StCheck, StDone} state_e;

    state_e           state_q;
    logic [2:0]       vec_q;
    logic [CntW-1:0]  cnt_q;
    logic             exp_sum;
    logic             exp_carry;
    logic             mismatch;
    logic [ERR_W-1:0] err_inc;

    assign a        = vec_q[2];
    assign b        = vec_q[1];
    assign carry_in = vec_q[0];

    always_comb begin
        exp_sum   = ^vec_q;
        exp_carry = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
        // One failure per vector, regardless of how many responses are wrong.
        mismatch  = (sum != exp_sum) || (carry_out != exp_carry);
        err_inc   = (err_count == {ERR_W{1'b1}}) ? err_count : err_count + ERR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            vec_q            <= '0;
            cnt_q            <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q          <= StDrive;
                        vec_q            <= '0;
                        cnt_q            <= '0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end
                StDrive: begin
                    if (cnt_q == CntLast) begin
                        state_q <= StCheck;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StCheck: begin
                    if (mismatch) begin
                        err_count <= err_inc;
                        if (!first_fail_valid) begin
                            first_fail_vec   <= vec_q;
                            first_fail_valid <= 1'b1;
                        end
                    end
                    if (vec_q == 3'd7) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= !mismatch && (err_count == '0);
                    end else begin
                        vec_q   <= vec_q + 3'd1;
                        cnt_q   <= '0;
                        state_q <= StDrive;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
